// File: rtl/atm_pkg.sv
// Shared ATM opcodes, response status codes and responder FSM states.
package atm_pkg;

  // Opcodes share the ATM front-end FSM state encoding.
  localparam logic [3:0] OP_BAL    = 4'd1;
  localparam logic [3:0] OP_WDR    = 4'd2;
  localparam logic [3:0] OP_DEP    = 4'd3;
  localparam logic [3:0] OP_XFR    = 4'd4;
  localparam logic [3:0] OP_NEWPIN = 4'd6;
  localparam logic [3:0] OP_PIN    = 4'd9;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_PIN  = 3'd1;
  localparam logic [2:0] ST_NO_FUNDS = 3'd2;
  localparam logic [2:0] ST_LOCKED   = 3'd3;
  localparam logic [2:0] ST_BAD_OP   = 3'd4;
  localparam logic [2:0] ST_OVERFLOW = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_RESP} state_t;

  function automatic logic op_known(input logic [3:0] op);
    return op inside {OP_BAL, OP_WDR, OP_DEP, OP_XFR, OP_NEWPIN, OP_PIN};
  endfunction

  // Ops whose response carries the source balance; PIN ops report 0.
  function automatic logic op_reports_bal(input logic [3:0] op);
    return op inside {OP_BAL, OP_WDR, OP_DEP, OP_XFR};
  endfunction

endpackage

// File: rtl/atm_acct_bank.sv
// Four-account store: balance, PIN, fail counter and lock flag per account.
module atm_acct_bank
  import atm_pkg::*;
#(
  parameter logic [7:0] INIT_BAL  = 8'd100,
  parameter logic [3:0] INIT_PIN  = 4'hA,
  parameter int         MAX_TRIES = 3
) (
  input  logic            clk,
  input  logic            rst,
  output logic [3:0][7:0] bal,
  output logic [3:0][3:0] pin,
  output logic [3:0]      locked,
  input  logic [1:0]      src_idx,
  input  logic [1:0]      dst_idx,
  input  logic            we_a,
  input  logic [7:0]      wa_bal,
  input  logic            we_b,
  input  logic [7:0]      wb_bal,
  input  logic            pin_we,
  input  logic [3:0]      pin_val,
  input  logic            fail_inc,
  input  logic            fail_clr
);

  localparam logic [1:0] LOCK_AT = MAX_TRIES[1:0];

  logic [3:0][1:0] fails;

  // Port a writes the source account, port b the transfer destination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        bal[i]    <= INIT_BAL;
        pin[i]    <= INIT_PIN;
        fails[i]  <= 2'd0;
        locked[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we_b && dst_idx == i[1:0])      bal[i] <= wb_bal;
        else if (we_a && src_idx == i[1:0]) bal[i] <= wa_bal;
        if (pin_we && src_idx == i[1:0]) pin[i] <= pin_val;
        if (src_idx == i[1:0]) begin
          if (fail_clr) fails[i] <= 2'd0;
          else if (fail_inc) begin
            fails[i] <= fails[i] + 2'd1;
            if (fails[i] + 2'd1 == LOCK_AT) locked[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/atm_bank_responder.sv
// Request/response front of the account bank: IDLE -> CHECK -> EXEC -> RESP.
module atm_bank_responder
  import atm_pkg::*;
#(
  parameter logic [7:0] INIT_BAL  = 8'd100,
  parameter logic [3:0] INIT_PIN  = 4'hA,
  parameter int         MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [1:0] req_acct,
  input  logic [1:0] req_dst,
  input  logic [3:0] req_pin,
  input  logic [7:0] req_amt,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_status,
  output logic [7:0] rsp_data
);

  state_t          state;
  logic [3:0]      op_q, pin_q;
  logic [1:0]      acct_q, dst_q;
  logic [7:0]      amt_q;
  logic [2:0]      st_q, chk_st;
  logic [3:0][7:0] bal;
  logic [3:0][3:0] pin;
  logic [3:0]      locked;
  logic [7:0]      src_bal, dst_bal, wa_bal, post_bal;
  logic [8:0]      dep_sum, xfr_sum;
  logic            we_a, we_b, pin_we, fail_inc, fail_clr;

  assign req_ready = (state == S_IDLE);
  assign src_bal   = bal[acct_q];
  assign dst_bal   = bal[dst_q];
  assign dep_sum   = {1'b0, src_bal} + {1'b0, amt_q};
  assign xfr_sum   = {1'b0, dst_bal} + {1'b0, amt_q};

  atm_acct_bank #(.INIT_BAL(INIT_BAL), .INIT_PIN(INIT_PIN), .MAX_TRIES(MAX_TRIES)) u_bank (
    .clk(clk), .rst(rst), .bal(bal), .pin(pin), .locked(locked),
    .src_idx(acct_q), .dst_idx(dst_q),
    .we_a(we_a), .wa_bal(wa_bal), .we_b(we_b), .wb_bal(xfr_sum[7:0]),
    .pin_we(pin_we), .pin_val(amt_q[3:0]),
    .fail_inc(fail_inc), .fail_clr(fail_clr)
  );

  // Status precedence: unknown op, lock, PIN, then operation outcome.
  always_comb begin
    chk_st = ST_OK;
    if (!op_known(op_q))            chk_st = ST_BAD_OP;
    else if (locked[acct_q])        chk_st = ST_LOCKED;
    else if (pin[acct_q] != pin_q)  chk_st = ST_BAD_PIN;
    else begin
      case (op_q)
        OP_WDR: if (amt_q > src_bal) chk_st = ST_NO_FUNDS;
        OP_DEP: if (dep_sum[8]) chk_st = ST_OVERFLOW;
        OP_XFR: if (dst_q != acct_q) begin
          if (amt_q > src_bal)  chk_st = ST_NO_FUNDS;
          else if (xfr_sum[8])  chk_st = ST_OVERFLOW;
        end
        default: ;
      endcase
    end
  end

  // Bank writes happen only in EXEC; a reset before EXEC leaves no trace.
  always_comb begin
    we_a     = 1'b0;
    we_b     = 1'b0;
    wa_bal   = src_bal;
    pin_we   = 1'b0;
    fail_inc = 1'b0;
    fail_clr = 1'b0;
    if (state == S_EXEC) begin
      fail_inc = (st_q == ST_BAD_PIN);
      fail_clr = st_q inside {ST_OK, ST_NO_FUNDS, ST_OVERFLOW};
      if (st_q == ST_OK) begin
        case (op_q)
          OP_WDR: begin we_a = 1'b1; wa_bal = src_bal - amt_q; end
          OP_DEP: begin we_a = 1'b1; wa_bal = dep_sum[7:0]; end
          OP_XFR: if (dst_q != acct_q) begin
            we_a = 1'b1; wa_bal = src_bal - amt_q; we_b = 1'b1;
          end
          OP_NEWPIN: pin_we = 1'b1;
          default: ;
        endcase
      end
    end
    post_bal = we_a ? wa_bal : src_bal;
  end

  // Transaction sequencer; response held until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= 4'd0;
      acct_q     <= 2'd0;
      dst_q      <= 2'd0;
      pin_q      <= 4'd0;
      amt_q      <= 8'd0;
      st_q       <= ST_OK;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_data   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q   <= req_op;
          acct_q <= req_acct;
          dst_q  <= req_dst;
          pin_q  <= req_pin;
          amt_q  <= req_amt;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          st_q  <= chk_st;
          state <= S_EXEC;
        end
        S_EXEC: begin
          rsp_status <= st_q;
          rsp_data   <= op_reports_bal(op_q) ? post_bal : 8'd0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Scoreboard bench: driver queues expected responses, monitor pops and checks.
module tb_atm_bank_responder;

  typedef struct packed { logic [2:0] st; logic [7:0] d; } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [3:0] req_op = 4'd0, req_pin = 4'd0;
  logic [1:0] req_acct = 2'd0, req_dst = 2'd0;
  logic [7:0] req_amt = 8'd0;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [2:0] rsp_status;
  logic [7:0] rsp_data;

  int   total = 0, bad = 0;
  int   cyc = 0, acc_cyc = 0;
  logic rsp_valid_d = 1'b0;
  exp_t q[$];

  atm_bank_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_acct(req_acct), .req_dst(req_dst), .req_pin(req_pin),
    .req_amt(req_amt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: inputs change only just after posedge, so the negedge view
  // is exactly what the next posedge will sample.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (rsp_valid && !rsp_valid_d) chk("latency", cyc - acc_cyc, 2);
      if (rsp_valid && !rsp_ready && q.size() != 0) begin
        chk("hold_status", int'(rsp_status), int'(q[0].st));
        chk("hold_data", int'(rsp_data), int'(q[0].d));
        chk("hold_req_ready", int'(req_ready), 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = q.pop_front();
          chk("status", int'(rsp_status), int'(e.st));
          chk("data", int'(rsp_data), int'(e.d));
        end
      end
      if (req_valid && req_ready) acc_cyc = cyc + 1;
    end
    rsp_valid_d = rsp_valid;
  end

  task automatic send(input logic [3:0] op, input logic [1:0] a, input logic [1:0] d,
                      input logic [3:0] p, input logic [7:0] amt);
    int n = 0;
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = op; req_acct = a; req_dst = d; req_pin = p; req_amt = amt;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    // Scramble the fields: the captured request must not follow them.
    req_valid = 1'b0; req_op = 4'd5; req_acct = ~a; req_dst = ~d; req_pin = ~p; req_amt = ~amt;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic txn(input logic [3:0] op, input logic [1:0] a, input logic [1:0] d,
                     input logic [3:0] p, input logic [7:0] amt,
                     input logic [2:0] est, input logic [7:0] ed);
    q.push_back('{st: est, d: ed});
    send(op, a, d, p, amt);
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_status", int'(rsp_status), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);

    // op acct dst pin amt | status data
    txn(4'd1, 2'd0, 2'd0, 4'hA, 8'd0,   3'd0, 8'd100); // balance
    txn(4'd2, 2'd1, 2'd0, 4'hA, 8'd101, 3'd2, 8'd100); // shortfall
    txn(4'd2, 2'd1, 2'd0, 4'hA, 8'd100, 3'd0, 8'd0);   // amt == balance
    txn(4'd9, 2'd2, 2'd0, 4'h3, 8'd0,   3'd1, 8'd0);
    txn(4'd9, 2'd2, 2'd0, 4'h3, 8'd0,   3'd1, 8'd0);
    txn(4'd9, 2'd2, 2'd0, 4'h3, 8'd0,   3'd1, 8'd0);   // third miss locks
    txn(4'd9, 2'd2, 2'd0, 4'hA, 8'd0,   3'd3, 8'd0);   // locked beats good PIN
    txn(4'd5, 2'd2, 2'd0, 4'hA, 8'd0,   3'd4, 8'd0);   // bad op beats lock
    txn(4'd3, 2'd3, 2'd0, 4'hA, 8'd156, 3'd5, 8'd100); // 256 overflows
    txn(4'd4, 2'd0, 2'd3, 4'hA, 8'd50,  3'd0, 8'd50);  // transfer
    txn(4'd1, 2'd3, 2'd0, 4'hA, 8'd0,   3'd0, 8'd150);
    txn(4'd6, 2'd0, 2'd0, 4'hA, 8'h07,  3'd0, 8'd0);   // new PIN 7
    txn(4'd1, 2'd0, 2'd0, 4'h7, 8'd0,   3'd0, 8'd50);
    txn(4'd1, 2'd0, 2'd0, 4'hA, 8'd0,   3'd1, 8'd50);  // old PIN rejected
    txn(4'd1, 2'd0, 2'd0, 4'h7, 8'd0,   3'd0, 8'd50);  // clears counter
    txn(4'd1, 2'd0, 2'd0, 4'hA, 8'd0,   3'd1, 8'd50);
    txn(4'd1, 2'd0, 2'd0, 4'hA, 8'd0,   3'd1, 8'd50);  // 2 misses, not locked
    txn(4'd1, 2'd0, 2'd0, 4'h7, 8'd0,   3'd0, 8'd50);
    txn(4'd3, 2'd1, 2'd0, 4'hA, 8'd255, 3'd0, 8'd255); // acct1 0 -> 255
    txn(4'd4, 2'd3, 2'd1, 4'hA, 8'd200, 3'd2, 8'd150); // shortfall beats dst overflow
    txn(4'd4, 2'd3, 2'd1, 4'hA, 8'd10,  3'd5, 8'd150); // dst overflow
    txn(4'd4, 2'd1, 2'd1, 4'hA, 8'd5,   3'd0, 8'd255); // self transfer
    txn(4'd2, 2'd3, 2'd0, 4'hA, 8'd150, 3'd0, 8'd0);

    // Backpressure: response held for 10+ cycles.
    rsp_ready = 1'b0;
    q.push_back('{st: 3'd0, d: 8'd255});
    send(4'd1, 2'd1, 2'd0, 4'hA, 8'd0);
    repeat (10) @(posedge clk);
    #2 rsp_ready = 1'b1;
    drain();

    // Reset during EXEC of a withdraw: no response, no balance change.
    send(4'd2, 2'd0, 2'd0, 4'h7, 8'd30);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    @(negedge clk); #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_rsp_valid", int'(rsp_valid), 0);
    chk("post_rst_queue", q.size(), 0);
    txn(4'd1, 2'd0, 2'd0, 4'hA, 8'd0,   3'd0, 8'd100);
    txn(4'd9, 2'd2, 2'd0, 4'hA, 8'd0,   3'd0, 8'd0);   // lock cleared by reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
